// File: rtl/pcecd_pkg.sv
// pcecd_pkg: bus phase codes, bus bit masks, status codes and FSM states shared by the
// PCE CD-ROM initiator and its testbench.
package pcecd_pkg;
   localparam logic [2:0] PHASE_COMMAND    = 3'b010;
   localparam logic [2:0] PHASE_DATA_IN    = 3'b001;
   localparam logic [2:0] PHASE_STATUS     = 3'b011;
   localparam logic [2:0] PHASE_MESSAGE_IN = 3'b111;
   localparam logic [4:0] BUS_IO  = 5'b00001;
   localparam logic [4:0] BUS_CD  = 5'b00010;
   localparam logic [4:0] BUS_MSG = 5'b00100;
   localparam logic [4:0] BUS_REQ = 5'b01000;
   localparam logic [4:0] BUS_BSY = 5'b10000;
   localparam logic [7:0] STATUS_GOOD            = 8'h00;
   localparam logic [7:0] STATUS_CHECK_CONDITION = 8'h02;
   typedef enum logic [2:0] {
      ST_IDLE, ST_SELECT, ST_WAIT_REQ, ST_DATA_HOLD, ST_WAIT_REL, ST_DONE, ST_ABORT, ST_RESET
   } state_t;
endpackage

// File: rtl/pcecd_cmd_buffer.sv
// pcecd_cmd_buffer: command byte store filled while idle and read out in order during the
// COMMAND phase; rewind restarts reading, clear empties it.
module pcecd_cmd_buffer #(
   parameter int CMD_MAX = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wr,
   input  logic [7:0]                din,
   input  logic                      rewind,
   input  logic                      rd,
   output logic [7:0]                dout,
   output logic [$clog2(CMD_MAX):0]  count,
   output logic                      drained
);
   localparam int AW = $clog2(CMD_MAX);
   localparam logic [AW:0] FULL = CMD_MAX[AW:0];
   logic [7:0] mem [CMD_MAX];
   logic [AW:0] rptr;
   logic push;
   assign push = wr && count != FULL;
   assign drained = rptr == count;
   assign dout = mem[rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (push)
         mem[count[AW-1:0]] <= din;
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
         rptr <= '0;
      end else begin
         count <= count + (AW+1)'(push);
         rptr <= rewind ? '0 : rptr + (AW+1)'(rd);
      end
   end
endmodule

// File: rtl/pcecd_scsi_initiator.sv
// pcecd_scsi_initiator: host end of the PCE CD-ROM bus; selects the target and runs the
// REQ/ACK handshake for COMMAND, DATA_IN, STATUS and MESSAGE_IN phases.
module pcecd_scsi_initiator
   import pcecd_pkg::*;
#(
   parameter int CMD_MAX        = 16,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int RST_CYCLES     = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cmd_wr,
   input  logic [7:0] i_cmd_byte,
   input  logic       i_start,
   input  logic       i_bus_reset,
   input  logic       i_bsy,
   input  logic       i_req,
   input  logic       i_msg,
   input  logic       i_cd,
   input  logic       i_io,
   input  logic [7:0] i_db,
   output logic       o_sel,
   output logic       o_ack,
   output logic       o_rst,
   output logic [7:0] o_db,
   output logic       o_data_valid,
   output logic [7:0] o_data_byte,
   input  logic       i_data_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_timeout,
   output logic [7:0] o_status,
   output logic [7:0] o_message
);
   localparam int TMAX = TIMEOUT_CYCLES > RST_CYCLES ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   localparam int CW = $clog2(CMD_MAX) + 1;
   state_t state, state_n;
   logic [TW-1:0] tmr;
   logic [CW-1:0] count;
   logic [7:0] cmd_byte;
   logic [4:0] bus;
   logic [2:0] phase;
   logic bsy, req, ph_cmd, ph_din, ph_st, ph_msg;
   logic drained, msg_seen, expired, rst_end, take, hit, wr_ok;
   assign bus = {i_bsy, i_req, i_msg, i_cd, i_io};
   assign bsy = |(bus & BUS_BSY);
   assign req = |(bus & BUS_REQ);
   assign phase = {|(bus & BUS_MSG), |(bus & BUS_CD), |(bus & BUS_IO)};
   assign ph_cmd = bsy && phase == PHASE_COMMAND;
   assign ph_din = bsy && phase == PHASE_DATA_IN;
   assign ph_st = bsy && phase == PHASE_STATUS;
   assign ph_msg = bsy && phase == PHASE_MESSAGE_IN;
   // An exhausted command buffer withholds ACK so the target has to move on to another phase.
   assign take = req && ((ph_cmd && !drained) || ph_din || ph_st || ph_msg);
   assign hit = state == ST_WAIT_REQ && take && !i_bus_reset;
   assign expired = tmr == TW'(TIMEOUT_CYCLES - 1);
   assign rst_end = tmr == TW'(RST_CYCLES - 1);
   assign wr_ok = i_cmd_wr && state == ST_IDLE;
   pcecd_cmd_buffer #(.CMD_MAX(CMD_MAX)) u_buf (
      .clk(i_clk), .rst(i_rst), .clr(i_bus_reset || state == ST_DONE),
      .wr(wr_ok), .din(i_cmd_byte), .rewind(state == ST_IDLE), .rd(hit && ph_cmd),
      .dout(cmd_byte), .count(count), .drained(drained)
   );
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:      state_n = i_start && (count != '0 || wr_ok) ? ST_SELECT : ST_IDLE;
         ST_SELECT:    state_n = bsy ? ST_WAIT_REQ : expired ? ST_ABORT : ST_SELECT;
         ST_WAIT_REQ:  state_n = !bsy ? (msg_seen ? ST_DONE : ST_ABORT)
                               : take ? (ph_din ? ST_DATA_HOLD : ST_WAIT_REL)
                               : expired ? ST_ABORT : ST_WAIT_REQ;
         ST_DATA_HOLD: state_n = i_data_ready ? ST_WAIT_REL : ST_DATA_HOLD;
         ST_WAIT_REL:  state_n = !req ? ST_WAIT_REQ : expired ? ST_ABORT : ST_WAIT_REL;
         ST_RESET:     state_n = rst_end ? ST_IDLE : ST_RESET;
         default:      state_n = ST_IDLE;
      endcase
      if (i_bus_reset)
         state_n = ST_RESET;
      o_sel = state == ST_SELECT;
      o_ack = state == ST_WAIT_REL;
      o_rst = state == ST_RESET;
      o_data_valid = state == ST_DATA_HOLD;
      o_busy = state != ST_IDLE;
      o_done = state == ST_DONE;
      o_timeout = state == ST_ABORT;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
         tmr <= '0;
         msg_seen <= 1'b0;
         o_db <= '0;
         o_data_byte <= '0;
         o_status <= '0;
         o_message <= '0;
      end else begin
         state <= state_n;
         tmr <= (state_n != state || i_bus_reset) ? '0 : tmr + 1'b1;
         msg_seen <= state == ST_IDLE ? 1'b0 : msg_seen || (hit && ph_msg);
         if (hit && ph_cmd)
            o_db <= cmd_byte;
         if (hit && ph_din)
            o_data_byte <= i_db;
         if (hit && ph_st)
            o_status <= i_db;
         if (hit && ph_msg)
            o_message <= i_db;
      end
   end
endmodule

// File: tb/tb_pcecd_scsi_initiator.sv
// tb_pcecd_scsi_initiator: phase-decode table, directed corner sequences and randomized
// transactions driven by a procedural target, checked against a queue-based model.
module tb_pcecd_scsi_initiator;
   import pcecd_pkg::*;
   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [2:0] ph;
      logic [7:0] db;
      logic       ack;
      logic       valid;
   } vec_t;
   logic i_clk = 1'b0;
   logic i_rst, i_cmd_wr, i_start, i_bus_reset, i_bsy, i_req, i_msg, i_cd, i_io, i_data_ready;
   logic [7:0] i_cmd_byte, i_db;
   logic o_sel, o_ack, o_rst, o_data_valid, o_busy, o_done, o_timeout;
   logic [7:0] o_db, o_data_byte, o_status, o_message;
   int checks = 0;
   int failures = 0;
   pcecd_scsi_initiator #(.CMD_MAX(16), .TIMEOUT_CYCLES(100), .RST_CYCLES(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cmd_wr(i_cmd_wr), .i_cmd_byte(i_cmd_byte),
      .i_start(i_start), .i_bus_reset(i_bus_reset), .i_bsy(i_bsy), .i_req(i_req),
      .i_msg(i_msg), .i_cd(i_cd), .i_io(i_io), .i_db(i_db), .o_sel(o_sel), .o_ack(o_ack),
      .o_rst(o_rst), .o_db(o_db), .o_data_valid(o_data_valid), .o_data_byte(o_data_byte),
      .i_data_ready(i_data_ready), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
      .o_status(o_status), .o_message(o_message)
   );
   always #5 i_clk = ~i_clk;
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic sig(input int w);
      return w == 0 ? o_sel : w == 1 ? o_ack : w == 2 ? o_data_valid : o_done;
   endfunction
   function automatic logic [7:0] captured(input logic [2:0] ph);
      return ph == PHASE_COMMAND ? o_db : ph == PHASE_DATA_IN ? o_data_byte :
             ph == PHASE_STATUS ? o_status : o_message;
   endfunction
   task automatic wait_for(input int w, input logic v, input string name);
      int n = 0;
      while (sig(w) !== v && n < 60) begin
         tick();
         n++;
      end
      chk(name, 32'(sig(w)), 32'(v));
   endtask
   task automatic drive_phase(input logic [2:0] ph, input logic [7:0] db);
      {i_msg, i_cd, i_io} = ph;
      i_db = db;
      i_req = 1'b1;
   endtask
   task automatic release_req(input string name);
      i_req = 1'b0;
      wait_for(1, 1'b0, name);
   endtask
   task automatic push_start(input logic [7:0] b);
      i_cmd_wr = 1'b1;
      i_cmd_byte = b;
      i_start = 1'b1;
      tick();
      i_cmd_wr = 1'b0;
      i_start = 1'b0;
   endtask
   task automatic rst_pulse_check(input string name);
      int n = 0;
      logic bad = 1'b0;
      while (o_rst && n < 100) begin
         bad |= o_done | o_timeout;
         tick();
         n++;
      end
      chk({name, "_rst_len"}, 32'(n), 32'd16);
      chk({name, "_no_pulse"}, 32'(bad), 32'd0);
   endtask
   // Model: the buffer keeps the first 16 pushed bytes; the target takes ntake of them in order.
   task automatic transaction(input string tag, input bq_t cmd, input int ntake, input bq_t din,
                              input int stall_idx, input int stall_len, input logic [7:0] st,
                              input logic [7:0] msg);
      int acc = cmd.size() > 16 ? 16 : cmd.size();
      for (int i = 0; i < cmd.size(); i++) begin
         i_cmd_wr = 1'b1;
         i_cmd_byte = cmd[i];
         i_start = (i == cmd.size() - 1);
         tick();
      end
      i_cmd_wr = 1'b0;
      i_start = 1'b0;
      wait_for(0, 1'b1, {tag, "_sel"});
      i_bsy = 1'b1;
      tick();
      chk({tag, "_sel_drop"}, 32'(o_sel), 32'd0);
      for (int i = 0; i < ntake; i++) begin
         drive_phase(PHASE_COMMAND, 8'h00);
         if (i < acc) begin
            wait_for(1, 1'b1, {tag, "_cmd_ack"});
            chk($sformatf("%s_cmd%0d", tag, i), 32'(o_db), 32'(cmd[i]));
         end else begin
            repeat (4) tick();
            chk({tag, "_cmd_noack"}, 32'(o_ack), 32'd0);
         end
         release_req({tag, "_cmd_rel"});
      end
      foreach (din[i]) begin
         drive_phase(PHASE_DATA_IN, din[i]);
         i_data_ready = 1'b0;
         wait_for(2, 1'b1, {tag, "_dv"});
         chk($sformatf("%s_din%0d", tag, i), 32'(o_data_byte), 32'(din[i]));
         if (i == stall_idx) begin
            repeat (stall_len) begin
               tick();
               chk({tag, "_stall"}, 32'({o_ack, o_data_valid}), 32'd1);
            end
         end
         i_data_ready = 1'b1;
         wait_for(1, 1'b1, {tag, "_din_ack"});
         chk({tag, "_dv_drop"}, 32'(o_data_valid), 32'd0);
         i_data_ready = 1'b0;
         release_req({tag, "_din_rel"});
      end
      drive_phase(PHASE_STATUS, st);
      wait_for(1, 1'b1, {tag, "_st_ack"});
      release_req({tag, "_st_rel"});
      chk({tag, "_status"}, 32'(o_status), 32'(st));
      drive_phase(PHASE_MESSAGE_IN, msg);
      wait_for(1, 1'b1, {tag, "_msg_ack"});
      release_req({tag, "_msg_rel"});
      chk({tag, "_message"}, 32'(o_message), 32'(msg));
      i_bsy = 1'b0;
      {i_msg, i_cd, i_io} = 3'b000;
      wait_for(3, 1'b1, {tag, "_done"});
      chk({tag, "_no_timeout"}, 32'(o_timeout), 32'd0);
      tick();
      chk({tag, "_idle"}, 32'({o_busy, o_done}), 32'd0);
   endtask
   initial begin
      vec_t tbl[9];
      bq_t c, d;
      int n, nt, nd;
      {i_rst, i_cmd_wr, i_cmd_byte, i_start, i_bus_reset, i_bsy, i_req} = '0;
      {i_msg, i_cd, i_io, i_db, i_data_ready} = '0;
      tbl[0] = '{3'b000, 8'h11, 1'b0, 1'b0};
      tbl[1] = '{PHASE_COMMAND, 8'h3c, 1'b1, 1'b0};
      tbl[2] = '{PHASE_COMMAND, 8'h3c, 1'b0, 1'b0};
      tbl[3] = '{3'b100, 8'h22, 1'b0, 1'b0};
      tbl[4] = '{3'b101, 8'h33, 1'b0, 1'b0};
      tbl[5] = '{3'b110, 8'h44, 1'b0, 1'b0};
      tbl[6] = '{PHASE_DATA_IN, 8'h77, 1'b0, 1'b1};
      tbl[7] = '{PHASE_STATUS, STATUS_CHECK_CONDITION, 1'b1, 1'b0};
      tbl[8] = '{PHASE_MESSAGE_IN, 8'h80, 1'b1, 1'b0};
      i_rst = 1'b1;
      repeat (3) tick();
      chk("reset_ctrl", 32'({o_sel, o_ack, o_rst, o_data_valid, o_busy, o_done, o_timeout}), 32'd0);
      chk("reset_data", {o_db, o_data_byte, o_status, o_message}, 32'd0);
      i_rst = 1'b0;
      tick();
      push_start(8'h3c);
      wait_for(0, 1'b1, "tbl_sel");
      i_bsy = 1'b1;
      tick();
      foreach (tbl[i]) begin
         drive_phase(tbl[i].ph, tbl[i].db);
         i_data_ready = 1'b0;
         tick();
         tick();
         chk($sformatf("tbl%0d_ack", i), 32'(o_ack), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d_valid", i), 32'(o_data_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            i_data_ready = 1'b1;
            tick();
            i_data_ready = 1'b0;
         end
         if (tbl[i].ack || tbl[i].valid)
            chk($sformatf("tbl%0d_value", i), 32'(captured(tbl[i].ph)), 32'(tbl[i].db));
         release_req($sformatf("tbl%0d_rel", i));
      end
      i_bsy = 1'b0;
      {i_msg, i_cd, i_io} = 3'b000;
      wait_for(3, 1'b1, "tbl_done");
      tick();
      push_start(8'h00);
      n = 0;
      while (!o_timeout && n < 300) begin
         tick();
         n++;
      end
      chk("timeout_window", 32'(n >= 100 && n <= 102), 32'd1);
      chk("timeout_sel", 32'(o_sel), 32'd0);
      tick();
      chk("timeout_after", 32'({o_busy, o_timeout}), 32'd0);
      i_bus_reset = 1'b1;
      tick();
      i_bus_reset = 1'b0;
      rst_pulse_check("clr");
      push_start(8'h5a);
      wait_for(0, 1'b1, "br_sel");
      i_bsy = 1'b1;
      tick();
      drive_phase(PHASE_COMMAND, 8'h00);
      wait_for(1, 1'b1, "br_cmd_ack");
      release_req("br_cmd_rel");
      drive_phase(PHASE_DATA_IN, 8'hc3);
      i_data_ready = 1'b0;
      wait_for(2, 1'b1, "br_dv");
      i_bus_reset = 1'b1;
      tick();
      i_bus_reset = 1'b0;
      chk("br_drop", 32'({o_ack, o_data_valid, o_rst}), 32'd1);
      {i_req, i_bsy, i_msg, i_cd, i_io} = '0;
      rst_pulse_check("br");
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("br_empty_start", 32'(o_busy), 32'd0);
      tick();
      c = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      d = {};
      transaction("tur", c, 6, d, -1, 0, STATUS_GOOD, 8'h00);
      c = {8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00};
      d = {8'ha5, 8'h5a, 8'h01, 8'hfe};
      transaction("read6", c, 6, d, 1, 10, STATUS_GOOD, 8'h00);
      c = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc};
      d = {};
      transaction("early", c, 3, d, -1, 0, STATUS_CHECK_CONDITION, 8'h00);
      c = {};
      for (int i = 0; i < 17; i++)
         c.push_back(8'(8'h40 + i));
      transaction("ovf", c, 17, d, -1, 0, STATUS_GOOD, 8'h00);
      for (int t = 0; t < 25; t++) begin
         c = {};
         d = {};
         n = $urandom_range(1, 18);
         for (int i = 0; i < n; i++)
            c.push_back(8'($urandom));
         nt = $urandom_range(0, (n > 16 ? 16 : n) + 1);
         nd = $urandom_range(0, 4);
         for (int i = 0; i < nd; i++)
            d.push_back(8'($urandom));
         transaction($sformatf("rnd%0d", t), c, nt, d, int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 12)), 8'($urandom), 8'($urandom));
      end
      i_rst = 1'b1;
      tick();
      chk("final_reset", {o_status, o_message, 8'(o_busy), 8'(o_done)}, 32'd0);
      i_rst = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcecd_scsi_initiator.md
Name: pcecd_scsi_initiator

Overview:
- Host (initiator) end of the PCE CD-ROM SCSI-like bus; the counterpart to the drive-side target emulation.
- Takes a command packet from the CPU-side register logic and selects the target, then runs the REQ/ACK handshake for COMMAND, DATA_IN, STATUS and MESSAGE_IN phases.
- Returns status/message bytes and streams data-in bytes to a consumer.
- Sits between the $1800-$1804 register model and the drive model, and is used as the bench driver for the drive.

Parameters:
- CMD_MAX, 16, depth of command byte buffer (power of 2, ≤256).
- TIMEOUT_CYCLES, 65535, max cycles spent in any wait state before abort.
- RST_CYCLES, 16, width of bus reset pulse in clocks.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_wr  in  1  push i_cmd_byte into command buffer (ignored while o_busy)
- i_cmd_byte  in  8  command byte
- i_start  in  1  begin transaction with buffered bytes (ignored if busy or buffer empty)
- i_bus_reset  in  1  request bus reset pulse (aborts any transaction)
- i_bsy, i_req, i_msg, i_cd, i_io  in  1 each  target-driven bus signals
- i_db  in  8  data bus from target
- o_sel, o_ack, o_rst  out  1 each  initiator-driven bus signals
- o_db  out  8  data bus to target (valid while o_ack in COMMAND phase)
- o_data_valid  out  1  data-in byte available
- o_data_byte  out  8  data-in byte
- i_data_ready  in  1  consumer accepts data-in byte
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse: transaction completed, bus free
- o_timeout  out  1  one-cycle pulse: transaction aborted
- o_status, o_message  out  8 each  last status/message bytes, held until next o_done

Behaviour:
- Reset: all outputs 0, buffer count 0, FSM IDLE.
- Phase decode from {msg,cd,io}, qualified by i_bsy=1:
  - 010 = COMMAND
  - 001 = DATA_IN
  - 011 = STATUS
  - 111 = MESSAGE_IN
  - any other code: do not handshake; keep waiting (timeout applies).
- FSM states:
  - IDLE: on i_start with count>0 -> SELECT.
  - SELECT: o_sel=1; on i_bsy=1 -> o_sel=0 next cycle, enter WAIT_REQ.
  - WAIT_REQ:
    - On i_req=1, act on the decoded phase:
      - COMMAND: drive o_db = buf[ptr] and assert o_ack in the same cycle; ptr++.
      - DATA_IN: capture i_db into o_data_byte, assert o_data_valid, go DATA_HOLD.
      - STATUS: capture o_status, assert o_ack.
      - MESSAGE_IN: capture o_message, assert o_ack, set msg_seen.
    - Then go WAIT_REL.
    - If i_bsy=0: go DONE if msg_seen, otherwise go ABORT.
  - DATA_HOLD: o_data_valid held until the i_data_ready handshake; then o_data_valid=0, o_ack=1 -> WAIT_REL.
  - WAIT_REL: on i_req=0 -> o_ack=0 -> WAIT_REQ.
  - DONE: o_done pulse; clear buffer count and msg_seen -> IDLE.
  - ABORT: drop sel/ack/valid; o_timeout pulse -> IDLE.
  - RESET: o_rst=1 for RST_CYCLES, then IDLE; no o_done or o_timeout pulse.
- COMMAND when ptr==count: do not ACK. The target is expected to change phase; this wait falls under timeout.
- Target leaves COMMAND early: remaining bytes are discarded; no error.
- Timeout counter: reloads on every state change; expiry in SELECT, WAIT_REQ or WAIT_REL -> ABORT. DATA_HOLD is exempt (consumer backpressure).
- i_bus_reset has priority over everything in any state: go to RESET, clear buffer.
- i_rst has priority over i_bus_reset.
- i_cmd_wr when count==CMD_MAX: dropped.
- Simultaneous i_cmd_wr and i_start in IDLE: the byte is written, and start uses the count including it.
- o_busy=1 in every state except IDLE.
- The bus is same-clock-domain; no synchronisers.

Decomposition:
- Shared package pcecd_pkg: phase encodings (matching drive-side PHASE_* values), bus bit masks (BUSY/REQ/MSG/CD/IO), SCSI status codes (GOOD=0x00, CHECK_CONDITION=0x02).
- Sub-module pcecd_cmd_buffer: CMD_MAX x 8 write-pointer/read-pointer buffer with count and clear.

Test Plan:
- Load 00 00 00 00 00 00 (TEST UNIT READY), start; target model handshakes 6 bytes then status 0x00, message 0x00 -> six ACKs with o_db matching each byte, o_status=0x00, o_message=0x00, o_done pulse after BSY falls.
- READ(6) 08 00 00 10 01 00; target sends 4 data bytes A5 5A 01 FE with i_data_ready low 10 cycles on byte 2 -> bytes emitted in order, o_ack held low during stall, status 0x00.
- Target never raises BSY after SEL; TIMEOUT_CYCLES=100 -> o_timeout pulse at 101±1 cycles, o_sel=0, o_busy=0.
- Target switches to STATUS after 3 of 6 command bytes, status 0x02 -> o_status=0x02, o_done, no timeout.
- Assert i_bus_reset mid DATA_IN -> o_ack/o_data_valid drop next cycle, o_rst high exactly RST_CYCLES, then IDLE with empty buffer.
- Write 17 bytes with CMD_MAX=16 -> 17th dropped; only 16 ACKed command bytes observed.
